// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl
//   Packs received UART bytes in pairs into 16-bit words, stores them at
//   sequential static-RAM addresses from 0, and on request streams every
//   stored word back to the UART transmitter, high byte first.
//
// Ports
//   clk, reset_n        clock (also the RAM clock) and async active-low reset
//   rx_data/rx_valid    received byte and its one-cycle strobe
//   dump_req            pulse: read back every stored word to the transmitter
//   clr                 pulse: empty the store (ignored during a dump)
//   tx_ready            transmitter can accept a byte
//   tx_data/tx_load     byte to transmit and its one-cycle strobe
//   ram_we/ram_addr/ram_din/ram_dout   static RAM port (1-cycle read latency)
//   wr_count            number of words stored (0 .. 2^ADDR_W)
//   busy                dump in progress
//   full                store holds 2^ADDR_W words
//   overflow            sticky: a byte was dropped (store full or dump active)
module uart_mem_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              dump_req,
  input  logic              clr,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_WAIT, RD_CAP, TX_HI, TX_HI_W, TX_LO, TX_LO_W
  } state_t;

  state_t              state_q, state_d;
  logic                phase_q, phase_d;       // 1: high byte held, waiting for low byte
  logic [7:0]          hold_q, hold_d;
  logic                dump_pend_q, dump_pend_d;
  logic [ADDR_W:0]     n_q, n_d;               // words to dump, captured at start
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                skip_q, skip_d;         // masks tx_ready in the cycle of tx_load
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_load_q, tx_load_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic                wr_issue;
  logic [ADDR_W:0]     rd_next;

  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    dump_pend_d = dump_pend_q;
    n_d         = n_q;
    rd_ptr_d    = rd_ptr_q;
    word_d      = word_q;
    skip_d      = skip_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    wr_count_d  = wr_count_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    wr_issue    = 1'b0;

    if (state_q == IDLE) begin
      if (clr) begin
        wr_count_d  = '0;
        phase_d     = 1'b0;
        overflow_d  = 1'b0;
        dump_pend_d = 1'b0;
      end else begin
        if (dump_req) dump_pend_d = 1'b1;
        if (rx_valid) begin
          if (!phase_q) begin
            hold_d  = rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (full_q) begin
              overflow_d = 1'b1;
            end else begin
              ram_we_d   = 1'b1;
              ram_addr_d = wr_count_q[ADDR_W-1:0];
              ram_din_d  = {hold_q, rx_data};
              wr_count_d = wr_count_q + 1'b1;
              wr_issue   = 1'b1;
            end
          end
        end
        // A write being issued or still on the RAM port holds the dump
        // back, so a word completed alongside the request is included.
        if (dump_pend_q && !ram_we_q && !wr_issue) begin
          if (wr_count_q == '0) begin
            dump_pend_d = 1'b0;
          end else begin
            n_d      = wr_count_q;
            rd_ptr_d = '0;
            busy_d   = 1'b1;
            state_d  = RD_ADDR;
          end
        end
      end
    end else begin
      // Dumping: incoming bytes are lost; phase and hold stay untouched.
      if (rx_valid) overflow_d = 1'b1;
      unique case (state_q)
        RD_ADDR: begin
          ram_addr_d = rd_ptr_q[ADDR_W-1:0];
          state_d    = RD_WAIT;
        end
        RD_WAIT: state_d = RD_CAP;
        RD_CAP: begin
          word_d  = ram_dout;
          state_d = TX_HI;
        end
        TX_HI: begin
          if (tx_ready) begin
            tx_load_d = 1'b1;
            tx_data_d = word_q[15:8];
            skip_d    = 1'b1;
            state_d   = TX_HI_W;
          end
        end
        TX_HI_W: begin
          if (skip_q)        skip_d  = 1'b0;
          else if (tx_ready) state_d = TX_LO;
        end
        TX_LO: begin
          if (tx_ready) begin
            tx_load_d = 1'b1;
            tx_data_d = word_q[7:0];
            skip_d    = 1'b1;
            state_d   = TX_LO_W;
          end
        end
        TX_LO_W: begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (tx_ready) begin
            if (rd_next < n_q) begin
              rd_ptr_d = rd_next;
              state_d  = RD_ADDR;
            end else begin
              busy_d      = 1'b0;
              dump_pend_d = 1'b0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    full_d = (wr_count_d == CAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      dump_pend_q <= 1'b0;
      n_q         <= '0;
      rd_ptr_q    <= '0;
      word_q      <= '0;
      skip_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      wr_count_q  <= '0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      dump_pend_q <= dump_pend_d;
      n_q         <= n_d;
      rd_ptr_q    <= rd_ptr_d;
      word_q      <= word_d;
      skip_q      <= skip_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      wr_count_q  <= wr_count_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_load  = tx_load_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign wr_count = wr_count_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule
